fetch_sequencer: RTL and testbench

- Initiator side of the instruction-fetch interface; sits between the branch/redirect logic and the instruction-memory fetch responder.
- Owns the PC, issues one word-aligned fetch request at a time and collects the returned instruction word.
- Buffers returned words with their PCs in a small FIFO and hands them to decode over a valid/ready handshake.
- Handles pipeline redirects: flushes the FIFO and discards any in-flight response.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_sequencer.sv | 116 +++++++++++
 tb/tb_fetch_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer and its buffer.
package fetch_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned XLEN   = 64;

    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ISSUE = 2'd0;
    localparam fetch_state_t WAIT  = 2'd1;
    localparam fetch_state_t DRAIN = 2'd2;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [XLEN-1:0]   pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction buffer; flush empties it immediately and beats push/pop.
module fetch_fifo #(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = logic [95:0]
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    input  logic                   flush,
    output entry_t                 head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   cnt;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !rst) mem[wr_ptr] <= push_data;
    end

    always_comb begin
        head = '0;
        if (!empty) head = mem[rd_ptr];
    end

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch initiator: owns the PC, keeps one request in flight and buffers returned words
// for decode. Redirects flush the buffer and drop any response already in flight.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0000_0000_0000_0000,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MEM_AW     = 10
) (
    input  logic        clk,
    input  logic        rst,
    output logic        fetch_req,
    output logic [63:0] fetch_addr,
    input  logic        fetch_done,
    input  logic [31:0] fetch_inst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [63:0] inst_pc
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || RESET_PC[1:0] != 2'b00
        || MEM_AW == 0 || MEM_AW > 62) begin : g_bad_param
        $error("fetch_sequencer: illegal parameter value");
    end

    fetch_state_t          state, state_next;
    logic [XLEN-1:0]       pc, pc_next;
    logic [XLEN-1:0]       req_pc, req_pc_next;
    logic [XLEN-1:0]       new_pc, issue_pc, addr_pc;
    logic                  req_int, push;
    logic                  pop;
    fetch_entry_t          head;
    logic                  fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign new_pc   = align_pc(redirect_pc);
    // A request issued in the redirect cycle already targets the new PC.
    assign issue_pc = redirect_valid ? new_pc : pc;

    always_comb begin
        state_next  = state;
        pc_next     = pc;
        req_pc_next = req_pc;
        req_int     = 1'b0;
        push        = 1'b0;
        case (state)
            ISSUE: begin
                if (redirect_valid || !fifo_full) begin
                    req_int     = 1'b1;
                    req_pc_next = issue_pc;
                    state_next  = WAIT;
                end
            end
            WAIT: begin
                if (fetch_done) begin
                    push       = !redirect_valid;
                    pc_next    = req_pc + 64'd4;
                    state_next = ISSUE;
                end else if (redirect_valid) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (fetch_done) state_next = ISSUE;
            end
            default: state_next = ISSUE;
        endcase
        if (redirect_valid) pc_next = new_pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ISSUE;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            req_pc <= req_pc_next;
        end
    end

    always_comb begin
        addr_pc = req_pc;
        if (rst) addr_pc = RESET_PC;
        else if (state == ISSUE) addr_pc = issue_pc;
    end

    assign fetch_req  = req_int && !rst;
    assign fetch_addr = {2'b00, addr_pc[XLEN-1:2]};

    assign inst_valid = (fifo_count != '0) && !rst;
    assign inst_data  = (fifo_empty || rst) ? '0 : head.inst;
    assign inst_pc    = (fifo_empty || rst) ? '0 : head.pc;
    assign pop        = inst_valid && inst_ready && !redirect_valid;

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ('{inst: fetch_inst, pc: req_pc}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: transaction-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_fetch_sequencer;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, fetch_req, fetch_done, redirect_valid, inst_valid, inst_ready;
    logic [63:0] fetch_addr, redirect_pc, inst_pc;
    logic [31:0] fetch_inst, inst_data;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .RESET_PC   (64'h0),
        .FIFO_DEPTH (DEPTH),
        .MEM_AW     (10)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_req      (fetch_req),
        .fetch_addr     (fetch_addr),
        .fetch_done     (fetch_done),
        .fetch_inst     (fetch_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: next PC to fetch, the one outstanding request, and the expected buffer.
    logic [63:0] m_pc, m_req_pc;
    bit          m_busy, m_stale;
    logic [95:0] m_q[$];

    int          lat = 1;
    int          resp_cnt = 0;
    logic [63:0] resp_addr = '0;
    bit          inj_done = 0;

    logic [63:0] req_log[$];
    logic [63:0] pop_log[$];
    int          pop_cyc[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ (a * 32'h0001_0003);
    endfunction

    task automatic clear_logs();
        req_log.delete();
        pop_log.delete();
        pop_cyc.delete();
    endtask

    task automatic cycle();
        bit          exp_req;
        logic [63:0] exp_addr_pc, rpc;
        fetch_done = (resp_cnt == 1) || inj_done;
        fetch_inst = (resp_cnt == 1) ? mem_word(resp_addr[31:0]) : 32'hDEAD_BEEF;
        rpc        = {redirect_pc[63:2], 2'b00};
        exp_req    = !m_busy && (redirect_valid || m_q.size() < DEPTH);
        exp_addr_pc = m_busy ? m_req_pc : (redirect_valid ? rpc : m_pc);
        #4;
        if (rst) begin
            check("rst_fetch_req", {63'b0, fetch_req}, 64'd0);
            check("rst_inst_valid", {63'b0, inst_valid}, 64'd0);
        end else begin
            check("fetch_req", {63'b0, fetch_req}, {63'b0, exp_req});
            check("fetch_addr", fetch_addr, exp_addr_pc >> 2);
            check("inst_valid", {63'b0, inst_valid}, {63'b0, m_q.size() != 0});
            check("inst_data", {32'b0, inst_data}, m_q.size() != 0 ? {32'b0, m_q[0][95:64]} : 64'd0);
            check("inst_pc", inst_pc, m_q.size() != 0 ? m_q[0][63:0] : 64'd0);
            if (fetch_req) req_log.push_back(fetch_addr);
            if (inst_valid && inst_ready && !redirect_valid) begin
                pop_log.push_back(inst_pc);
                pop_cyc.push_back(cyc);
            end
        end
        // Responder reacts to what the DUT actually requested.
        if (rst) resp_cnt = 0;
        else begin
            if (resp_cnt > 0) resp_cnt--;
            if (fetch_req) begin
                resp_cnt  = lat;
                resp_addr = fetch_addr;
            end
        end
        if (rst) begin
            m_q.delete();
            m_pc = 64'h0; m_req_pc = 64'h0; m_busy = 0; m_stale = 0;
        end else begin
            if (m_q.size() != 0 && inst_ready && !redirect_valid) void'(m_q.pop_front());
            if (redirect_valid) m_q.delete();
            if (m_busy && fetch_done) begin
                if (!m_stale && !redirect_valid) begin
                    m_q.push_back({fetch_inst, m_req_pc});
                    m_pc = m_req_pc + 64'd4;
                end
                m_busy = 0;
            end else if (m_busy && redirect_valid) begin
                m_stale = 1;
            end
            if (redirect_valid) m_pc = rpc;
            if (exp_req) begin
                m_busy = 1; m_stale = 0; m_req_pc = m_pc;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; fetch_done = 0; fetch_inst = '0;
        redirect_valid = 0; redirect_pc = '0; inst_ready = 0;

        // 1: back-to-back fetch with 1-cycle responder
        do_reset();
        check("reset_inst_valid", {63'b0, inst_valid}, 64'd0);
        check("reset_fetch_addr", fetch_addr, 64'd0);
        inst_ready = 1; lat = 1; clear_logs();
        repeat (12) cycle();
        check("t1_req_count_ge4", {63'b0, req_log.size() >= 4}, 64'd1);
        check("t1_pop_count_ge4", {63'b0, pop_log.size() >= 4}, 64'd1);
        for (int i = 0; i < 4 && i < req_log.size(); i++)
            check("t1_req_addr", req_log[i], 64'(i));
        for (int i = 0; i < 4 && i < pop_log.size(); i++)
            check("t1_inst_pc", pop_log[i], 64'(4 * i));
        for (int i = 0; i + 1 < 4 && i + 1 < pop_cyc.size(); i++)
            check("t1_spacing", 64'(pop_cyc[i+1] - pop_cyc[i]), 64'd2);

        // 2: decode stalled, buffer fills, then drains in order
        do_reset();
        inst_ready = 0; lat = 1; clear_logs();
        repeat (20) cycle();
        check("t2_req_count", 64'(req_log.size()), 64'd4);
        check("t2_req_held", {63'b0, fetch_req}, 64'd0);
        clear_logs();
        inst_ready = 1;
        repeat (10) cycle();
        for (int i = 0; i < 4 && i < pop_log.size(); i++)
            check("t2_drain_pc", pop_log[i], 64'(4 * i));
        check("t2_resume_addr", req_log.size() != 0 ? req_log[0] : 64'hFFFF, 64'h4);

        // 3: redirect while waiting for a response
        do_reset();
        inst_ready = 1; lat = 3;
        for (int i = 0; i < 20 && resp_cnt != 2; i++) cycle();
        check("t3_in_wait", 64'(resp_cnt), 64'd2);
        clear_logs();
        redirect_valid = 1; redirect_pc = 64'h1003;
        cycle();
        redirect_valid = 0;
        repeat (15) cycle();
        check("t3_first_addr", req_log.size() != 0 ? req_log[0] : 64'hFFFF, 64'h400);
        check("t3_first_pc", pop_log.size() != 0 ? pop_log[0] : 64'hFFFF, 64'h1000);

        // 4: redirect coincides with fetch_done
        do_reset();
        inst_ready = 1; lat = 1;
        for (int i = 0; i < 20 && resp_cnt != 1; i++) cycle();
        check("t4_done_due", 64'(resp_cnt), 64'd1);
        clear_logs();
        redirect_valid = 1; redirect_pc = 64'h2000;
        cycle();
        redirect_valid = 0;
        check("t4_req_next", {63'b0, fetch_req}, 64'd1);
        check("t4_addr_next", fetch_addr, 64'h800);
        repeat (6) cycle();
        check("t4_first_pc", pop_log.size() != 0 ? pop_log[0] : 64'hFFFF, 64'h2000);

        // 5: 3-cycle responder latency
        do_reset();
        inst_ready = 1; lat = 3; clear_logs();
        repeat (30) cycle();
        check("t5_req_count", 64'(req_log.size()), 64'd8);
        for (int i = 0; i < 3 && i < pop_log.size(); i++)
            check("t5_inst_pc", pop_log[i], 64'(4 * i));

        // 6: reset in WAIT with two buffered entries, stale response afterwards
        do_reset();
        inst_ready = 0; lat = 3;
        for (int i = 0; i < 40 && !(m_q.size() == 2 && resp_cnt == 2); i++) cycle();
        check("t6_valid_before", {63'b0, inst_valid}, 64'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("t6_valid_after", {63'b0, inst_valid}, 64'd0);
        check("t6_addr_after", fetch_addr, 64'd0);
        clear_logs();
        inj_done = 1;
        cycle();
        inj_done = 0;
        inst_ready = 1;
        repeat (12) cycle();
        check("t6_first_pc", pop_log.size() != 0 ? pop_log[0] : 64'hFFFF, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
